// File: rtl/sram_fb_reader.sv
// rtl/sram_fb_reader.sv - streams one frame of 16-bit pixels from async SRAM into a show-ahead FIFO
module sram_fb_reader #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter logic [19:0] BASE_ADDR  = 20'h00000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        SRAM_EN,
    input  logic        frame_start,
    input  logic        pix_rd,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        underflow,
    output logic        frame_done,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N
);

    localparam int FRAME_WORDS = H_RES * V_RES;
    localparam int WC_W        = $clog2(FRAME_WORDS + 1);
    localparam int AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW          = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t          state;
    logic [19:0]     rd_addr;
    logic [WC_W-1:0] wcount;
    logic            en_d;

    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fcount;

    logic            fifo_empty;
    logic            fifo_full;
    logic            capture;
    logic            pop;

    // The bus is only ours while granted; otherwise every pin floats. DQ is read-only here.
    assign SRAM_ADDR = SRAM_EN ? rd_addr : 20'hzzzzz;
    assign SRAM_CE_N = SRAM_EN ? 1'b0 : 1'bz;
    assign SRAM_OE_N = SRAM_EN ? 1'b0 : 1'bz;
    assign SRAM_UB_N = SRAM_EN ? 1'b0 : 1'bz;
    assign SRAM_LB_N = SRAM_EN ? 1'b0 : 1'bz;
    assign SRAM_WE_N = SRAM_EN ? 1'b1 : 1'bz;
    assign SRAM_DQ   = 16'hzzzz;

    // Capture needs a grant that has already been held one full cycle so the address
    // has settled for 20 ns; frame_start overrides both capture and pop.
    always_comb begin
        fifo_empty = (fcount == '0);
        fifo_full  = (fcount == CW'(FIFO_DEPTH));
        capture    = (state == S_FETCH) && SRAM_EN && en_d
                     && (!fifo_full || pix_rd) && !frame_start;
        pop        = pix_rd && !fifo_empty && !frame_start;
        pix_valid  = !fifo_empty;
        pix_data   = fifo_empty ? 16'h0000 : mem[rd_ptr];
    end

    // Delayed copy of the bus grant, used to skip the first (unsettled) granted cycle.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            en_d <= 1'b0;
        end else begin
            en_d <= SRAM_EN;
        end
    end

    // Fetch sequencer: address, word count and frame-done flag; the word count ends the frame.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_addr    <= BASE_ADDR;
            wcount     <= '0;
            frame_done <= 1'b0;
        end else if (frame_start) begin
            state      <= S_FETCH;
            rd_addr    <= BASE_ADDR;
            wcount     <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (capture) begin
                        rd_addr <= rd_addr + 20'd1;
                        wcount  <= wcount + WC_W'(1);
                        if (wcount == WC_W'(FRAME_WORDS - 1)) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                S_DONE:  frame_done <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; only written on a capture, so no reset is needed.
    always_ff @(posedge clk50) begin
        if (capture) begin
            mem[wr_ptr] <= SRAM_DQ;
        end
    end

    // FIFO pointers, occupancy and sticky underflow.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcount    <= '0;
            underflow <= 1'b0;
        end else if (frame_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcount    <= '0;
            underflow <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({capture, pop})
                2'b10:   fcount <= fcount + CW'(1);
                2'b01:   fcount <= fcount - CW'(1);
                default: fcount <= fcount;
            endcase
            if (pix_rd && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_fb_reader.sv
// tb/tb_sram_fb_reader.sv - directed self-checking bench for sram_fb_reader
`timescale 1ns/1ps
module tb_sram_fb_reader;

    logic        clk50 = 1'b0;
    logic        rst;
    logic        sram_en;
    logic        frame_start;
    logic        pix_rd;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        frame_done;

    tri0 [19:0]  sram_addr;
    wire [15:0]  sram_dq;
    tri1         sram_ce_n;
    tri1         sram_oe_n;
    tri1         sram_ub_n;
    tri1         sram_lb_n;
    tri0         sram_we_n;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_pix;
    int          n_pops;

    // SRAM model: data equals the low address bits while the grant is held.
    assign sram_dq = sram_en ? sram_addr[15:0] : 16'hzzzz;

    always #10 clk50 = ~clk50;

    sram_fb_reader #(
        .H_RES(4), .V_RES(3), .BASE_ADDR(20'h00100), .FIFO_DEPTH(4)
    ) dut (
        .clk50(clk50), .rst(rst), .SRAM_EN(sram_en), .frame_start(frame_start),
        .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
        .underflow(underflow), .frame_done(frame_done), .SRAM_ADDR(sram_addr),
        .SRAM_DQ(sram_dq), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // Advance one cycle, scoring the pixel popped on that edge against the running expectation.
    task automatic tick_pop();
        logic        did;
        logic [15:0] v;
        did = pix_rd && pix_valid;
        v   = pix_data;
        tick();
        if (did) begin
            check_eq("pop_seq", {16'h0, v}, {16'h0, exp_pix});
            exp_pix = exp_pix + 16'd1;
            n_pops++;
        end
    endtask

    task automatic check_hiz(input string tag);
        check_eq({tag, "_addr_z"}, {12'h0, sram_addr}, 32'h0);
        check_eq({tag, "_ce_z"}, {31'h0, sram_ce_n}, 32'h1);
        check_eq({tag, "_oe_z"}, {31'h0, sram_oe_n}, 32'h1);
        check_eq({tag, "_we_z"}, {31'h0, sram_we_n}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; sram_en = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check_eq("rst_valid", {31'h0, pix_valid}, 32'h0);
        check_eq("rst_data", {16'h0, pix_data}, 32'h0);
        check_eq("rst_uflow", {31'h0, underflow}, 32'h0);
        check_eq("rst_done", {31'h0, frame_done}, 32'h0);
        check_hiz("rst");

        // pop while empty after reset
        pix_rd = 1'b1;
        tick();
        pix_rd = 1'b0;
        check_eq("uf_set", {31'h0, underflow}, 32'h1);
        check_eq("uf_data", {16'h0, pix_data}, 32'h0);
        repeat (3) tick();
        check_eq("uf_sticky", {31'h0, underflow}, 32'h1);

        // full frame, continuous read
        sram_en = 1'b1;
        tick();
        #1;
        check_eq("en_ce", {31'h0, sram_ce_n}, 32'h0);
        check_eq("en_we", {31'h0, sram_we_n}, 32'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("f1_uf_clr", {31'h0, underflow}, 32'h0);
        check_eq("f1_empty", {31'h0, pix_valid}, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            pix_rd = 1'b1;
            check_eq("f1_data", {16'h0, pix_data}, 32'h100 + 32'(k - 1));
            check_eq("f1_valid", {31'h0, pix_valid}, 32'h1);
            check_eq("f1_done", {31'h0, frame_done}, (k == 12) ? 32'h1 : 32'h0);
            check_eq("f1_uf", {31'h0, underflow}, 32'h0);
        end
        tick();
        check_eq("f1_drain_valid", {31'h0, pix_valid}, 32'h0);
        check_eq("f1_drain_data", {16'h0, pix_data}, 32'h0);
        check_eq("f1_drain_uf", {31'h0, underflow}, 32'h0);
        tick();
        check_eq("f1_end_uf", {31'h0, underflow}, 32'h1);

        // FIFO fill without reads, then resume
        pix_rd = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (7) tick();
        check_eq("full_addr", {12'h0, sram_addr}, 32'h104);
        check_eq("full_head", {16'h0, pix_data}, 32'h100);
        pix_rd = 1'b1;
        exp_pix = 16'h100;
        n_pops = 0;
        repeat (20) tick_pop();
        check_eq("full_pops", 32'(n_pops), 32'd12);
        check_eq("full_done", {31'h0, frame_done}, 32'h1);

        // grant toggling every 3 cycles
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_pix = 16'h100;
        n_pops = 0;
        for (int c = 0; c < 300 && n_pops < 12; c++) begin
            sram_en = ((c / 3) % 2) == 0;
            #2;
            if (!sram_en) check_hiz("tog");
            tick_pop();
        end
        check_eq("tog_pops", 32'(n_pops), 32'd12);

        // frame_start mid-frame
        sram_en = 1'b1;
        pix_rd = 1'b1;
        tick();
        check_eq("mid_pre_uf", {31'h0, underflow}, 32'h1);
        check_eq("mid_pre_done", {31'h0, frame_done}, 32'h1);
        pix_rd = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("mid_uf_clr", {31'h0, underflow}, 32'h0);
        check_eq("mid_done_clr", {31'h0, frame_done}, 32'h0);
        tick();
        pix_rd = 1'b1;
        repeat (4) tick();
        check_eq("mid_head5", {16'h0, pix_data}, 32'h104);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_rd = 1'b0;
        check_eq("mid_flush_valid", {31'h0, pix_valid}, 32'h0);
        check_eq("mid_flush_data", {16'h0, pix_data}, 32'h0);
        check_eq("mid_flush_uf", {31'h0, underflow}, 32'h0);
        tick();
        check_eq("mid_restart", {16'h0, pix_data}, 32'h100);

        // async reset during fetch
        repeat (2) tick();
        @(posedge clk50);
        #5 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'h0, pix_valid}, 32'h0);
        check_eq("arst_data", {16'h0, pix_data}, 32'h0);
        check_eq("arst_done", {31'h0, frame_done}, 32'h0);
        check_eq("arst_addr", {12'h0, sram_addr}, 32'h100);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("arst_nocap", {31'h0, pix_valid}, 32'h0);
        check_eq("arst_hold", {12'h0, sram_addr}, 32'h100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check_eq("arst_restart", {16'h0, pix_data}, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
